// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared constants for the multicycle RV32I controller.
// Holds opcode values, FSM state encodings, ALUControl codes, the ALUOp
// classes handed to the ALU decoder, and the ImmSrc/ResultSrc/ALUSrcA/ALUSrcB
// mux codes, plus the opcode-to-ImmSrc helper.
package riscv_ctrl_pkg;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StLui      = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10,
        StJal      = 4'd11,
        StJalr     = 4'd12,
        StJalrWb   = 4'd13,
        StHalt     = 4'd14
    } state_e;

    // ALUControl codes
    localparam logic [2:0] AluAdd  = 3'd0;
    localparam logic [2:0] AluSub  = 3'd1;
    localparam logic [2:0] AluAnd  = 3'd2;
    localparam logic [2:0] AluOr   = 3'd3;
    localparam logic [2:0] AluXor  = 3'd4;
    localparam logic [2:0] AluSlt  = 3'd5;
    localparam logic [2:0] AluSltu = 3'd6;

    // ALUOp classes driven by the FSM into the ALU decoder
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResMemData   = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Immediate format selected purely by opcode
    function automatic logic [2:0] imm_src_of(logic [6:0] op);
        case (op)
            OpStore:  return ImmS;
            OpBranch: return ImmB;
            OpJal:    return ImmJ;
            OpLui:    return ImmU;
            default:  return ImmI;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALUControl decode.
// Ports:
//   alu_op_i[1:0]      class from the FSM (add / sub / decode from funct fields)
//   funct3_i[2:0]      Instr[14:12]
//   funct7b5_i         Instr[30]
//   op5_i              Instr[5]; 1 for R-type, 0 for I-type ALU ops
//   alu_control_o[2:0] ALU operation code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        case (alu_op_i)
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    // I-type has no subtract; funct7b5 there is immediate bits
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b011:  alu_control_o = AluSltu;
                    3'b100:  alu_control_o = AluXor;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller: multicycle RV32I control FSM.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the shared datapath's mux selects, write strobes and ALUControl.
// Ports:
//   clk, rst (async, active-high)       clock and reset
//   op_i, funct3_i, funct7b5_i          instruction fields from the IR
//   zero_i, bge_i, lt_i                 ALU comparison flags
//   pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o   strobes/selects
//   result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o, alu_control_o
//   illegal_o                           trap flag
// Build option: CTRL_ILLEGAL_TRAP_EN makes an unknown opcode halt the FSM
// with illegal_o=1 until reset; otherwise it retires as a two-cycle NOP and
// illegal_o is tied low.
module riscv_multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       bge_i,
    input  logic       lt_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] imm_src_o,
    output logic [2:0] alu_control_o,
    output logic       illegal_o
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // Mux defaults are the FETCH values; strobes default off
        state_d      = StFetch;
        pc_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = ResAluResult;
        alu_src_a_o  = SrcAPc;
        alu_src_b_o  = SrcBFour;
        alu_op       = AluOpAdd;

        case (state_q)
            StFetch: begin
                ir_write_o = 1'b1;
                pc_write_o = 1'b1;
                state_d    = StDecode;
            end
            StDecode: begin
                // Precompute branch/JAL target into ALUOut
                alu_src_a_o = SrcAOldPc;
                alu_src_b_o = SrcBImm;
                case (op_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:         state_d = StHalt;
`else
                    default:         state_d = StFetch;
`endif
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = SrcARs1;
                alu_src_b_o = SrcBImm;
                state_d     = (op_i == OpStore) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src_o = 1'b1;
                state_d   = StMemWb;
            end
            StMemWb: begin
                result_src_o = ResMemData;
                reg_write_o  = 1'b1;
            end
            StMemWrite: begin
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            StExecR: begin
                alu_src_a_o = SrcARs1;
                alu_src_b_o = SrcBRs2;
                alu_op      = AluOpFunct;
                state_d     = StAluWb;
            end
            StExecI: begin
                alu_src_a_o = SrcARs1;
                alu_src_b_o = SrcBImm;
                alu_op      = AluOpFunct;
                state_d     = StAluWb;
            end
            StLui: begin
                alu_src_a_o = SrcAZero;
                alu_src_b_o = SrcBImm;
                state_d     = StAluWb;
            end
            StAluWb: begin
                result_src_o = ResAluOut;
                reg_write_o  = 1'b1;
            end
            StBranch: begin
                alu_src_a_o  = SrcARs1;
                alu_src_b_o  = SrcBRs2;
                alu_op       = AluOpSub;
                result_src_o = ResAluOut;
                case (funct3_i)
                    3'b000:  pc_write_o = zero_i;
                    3'b001:  pc_write_o = ~zero_i;
                    3'b100:  pc_write_o = lt_i;
                    3'b101:  pc_write_o = bge_i;
                    default: pc_write_o = 1'b0;
                endcase
            end
            StJal: begin
                // Jump to ALUOut target while ALU forms the link value
                alu_src_a_o  = SrcAOldPc;
                alu_src_b_o  = SrcBFour;
                result_src_o = ResAluOut;
                pc_write_o   = 1'b1;
                state_d      = StAluWb;
            end
            StJalr: begin
                alu_src_a_o  = SrcARs1;
                alu_src_b_o  = SrcBImm;
                result_src_o = ResAluResult;
                pc_write_o   = 1'b1;
                state_d      = StJalrWb;
            end
            StJalrWb: begin
                alu_src_a_o  = SrcAOldPc;
                alu_src_b_o  = SrcBFour;
                result_src_o = ResAluResult;
                reg_write_o  = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: state_d = StFetch;
        endcase

        // No write may escape while reset is held
        if (rst) begin
            pc_write_o  = 1'b0;
            ir_write_o  = 1'b0;
            reg_write_o = 1'b0;
            mem_write_o = 1'b0;
        end
    end

    assign imm_src_o = imm_src_of(op_i);

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_o = (state_q == StHalt);
`else
    assign illegal_o = 1'b0;
`endif

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3_i),
        .funct7b5_i    (funct7b5_i),
        .op5_i         (op_i[5]),
        .alu_control_o (alu_control_o)
    );

endmodule
